// File: rtl/x_filter_arbiter_if.sv
// Handshake bundle for x_filter_arbiter: NUM_REQ requester channels in, one tagged output channel out.
// Every channel: a word moves on a rising clk edge exactly when valid and ready are both 1; the sender holds valid/data steady until then, and ready may depend combinationally on valid.
interface x_filter_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32,
    parameter int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [BUS_WIDTH-1:0]         out_data_o;
    logic [ID_WIDTH-1:0]          out_id_o;
    logic                         out_filtered_o;

    modport slave (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, out_valid_o, out_data_o, out_id_o, out_filtered_o
    );

    modport master (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_data_o, out_id_o, out_filtered_o
    );
endinterface

// File: rtl/x_filter_arbiter.sv
// Round-robin shared X/Z scrub engine: grants one requester word per cycle, scrubs it per that
// requester's fill mode and registers it, with its id, into a single output stage.
module x_filter_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          BUS_WIDTH = 32,
    parameter int          CNT_WIDTH = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    x_filter_arbiter_if.slave    bus,
    input  logic [2*NUM_REQ-1:0] cfg_mode_i,
    input  logic                 cfg_filter_x_i,
    input  logic                 cfg_filter_z_i,
    input  logic                 clr_cnt_i,
    output logic [CNT_WIDTH-1:0] filt_cnt_o,
    output logic                 dbg_state_o
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int POP_W = $clog2(BUS_WIDTH + 1);
    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [31:0]          lfsr_q, lfsr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 filt_q, filt_d;

    logic                 stage_free;
    logic                 grant_found;
    logic                 accept;
    logic [ID_W-1:0]      grant_idx;
    logic [BUS_WIDTH-1:0] grant_word;
    logic [1:0]           grant_mode;
    logic [BUS_WIDTH-1:0] scrub_word;
    logic [POP_W-1:0]     pop_cnt;
    logic [CNT_WIDTH:0]   cnt_sum;

    // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_v;
        idx         = 0;
        idx_v       = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_v = idx[ID_W-1:0];
            if (!grant_found && bus.req_valid_i[idx_v]) begin
                grant_found = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

    always_comb begin
        grant_word = '0;
        grant_mode = 2'd0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == grant_idx) begin
                grant_word = bus.req_data_i[r*BUS_WIDTH +: BUS_WIDTH];
                grant_mode = cfg_mode_i[2*r +: 2];
            end
        end
    end

    // Mode 3 is a pure bypass: nothing is a candidate, so nothing is counted.
    always_comb begin
        scrub_word = grant_word;
        pop_cnt    = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if ((grant_mode != 2'd3) &&
                ((cfg_filter_x_i && (grant_word[i] === 1'bx)) ||
                 (cfg_filter_z_i && $isunknown(grant_word[i]) && (grant_word[i] !== 1'bx)))) begin
                case (grant_mode)
                    2'd0:    scrub_word[i] = 1'b0;
                    2'd1:    scrub_word[i] = 1'b1;
                    default: scrub_word[i] = lfsr_q[5'(i % 32)];
                endcase
                pop_cnt = pop_cnt + POP_W'(1);
            end
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(pop_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            rr_q    <= '0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            filt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            filt_q  <= filt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        id_d    = id_q;
        filt_d  = filt_q;
        if (accept) begin
            state_d = ST_FULL;
            rr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
            data_d  = scrub_word;
            id_d    = grant_idx;
            filt_d  = (pop_cnt != '0);
            if (grant_mode == 2'd2) lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end else if ((state_q == ST_FULL) && bus.out_ready_i) begin
            state_d = ST_EMPTY;
        end
        // A clear wins over a same-cycle accept; that word's bits are not counted.
        if (clr_cnt_i) cnt_d = '0;
        else if (accept) cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_comb begin
        stage_free      = (state_q == ST_EMPTY) || bus.out_ready_i;
        accept          = !rst_i && stage_free && grant_found;
        bus.req_ready_o = '0;
        if (accept) bus.req_ready_o[grant_idx] = 1'b1;
        bus.out_valid_o    = (state_q == ST_FULL);
        bus.out_data_o     = data_q;
        bus.out_id_o       = id_q;
        bus.out_filtered_o = filt_q;
        filt_cnt_o         = cnt_q;
        dbg_state_o        = (state_q == ST_FULL);
    end
endmodule

// File: tb/tb_x_filter_arbiter.sv
// Bench for x_filter_arbiter: arbitration vector table, directed corner sequences and a
// randomized run, all scored against a queue-based reference model.
module tb_x_filter_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int CW = 16;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int EW = 1 + 2 + W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  x_filter_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W), .ID_WIDTH(2)) bus ();

  logic [2*N-1:0] mode;
  logic fx, fz, clr, ordy, dbg;
  logic [CW-1:0] cnt;
  logic [N-1:0] valid;
  logic [W-1:0] word [N];

  always_comb begin
    bus.req_valid_i = valid;
    bus.out_ready_i = ordy;
    bus.req_data_i = '0;
    for (int r = 0; r < N; r++) bus.req_data_i[r*W +: W] = word[r];
  end

  x_filter_arbiter #(.NUM_REQ(N), .BUS_WIDTH(W), .CNT_WIDTH(CW), .LFSR_SEED(SEED)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .cfg_mode_i(mode),
    .cfg_filter_x_i(fx), .cfg_filter_z_i(fz), .clr_cnt_i(clr),
    .filt_cnt_o(cnt), .dbg_state_o(dbg)
  );

  // Reference model: pending output words, RR pointer, LFSR and counter.
  logic [EW-1:0] exp_q[$];
  int m_ptr, m_cnt;
  bit [31:0] m_lfsr;
  int total, bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] lfsr_next(input bit [31:0] s);
    bit [31:0] mask;
    int taps [4];
    taps = '{32, 22, 2, 1};
    mask = '0;
    foreach (taps[t]) mask[5'(taps[t] - 1)] = 1'b1;
    return (s >> 1) ^ (s[0] ? mask : 32'h0);
  endfunction

  function automatic void scrub(input logic [W-1:0] w, input int md, input bit xf, input bit zf,
                                input bit [31:0] lf, output logic [W-1:0] o, output int pop);
    bit is_x, is_z;
    o = w;
    pop = 0;
    if (md == 3) return;
    for (int i = 0; i < W; i++) begin
      is_x = (w[i] === 1'bx);
      is_z = $isunknown(w[i]) && !is_x;
      if ((is_x && xf) || (is_z && zf)) begin
        o[i] = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : lf[i % 32];
        pop++;
      end
    end
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    int kind, s;
    w = '0;
    kind = $urandom_range(0, 3);
    for (int i = 0; i < W; i++) begin
      s = $urandom_range(0, 9);
      w[i] = (kind == 0 || s < 7) ? 1'($urandom_range(0, 1)) : 1'bx;
    end
    return w;
  endfunction

  // Compare DUT against the model for the current cycle, then advance both across one edge.
  task automatic tick(output int g);
    bit free;
    logic [N-1:0] er;
    logic [W-1:0] sw;
    int pop, md, r;
    #1;
    free = (exp_q.size() == 0) || ordy;
    g = -1;
    pop = 0;
    if (!rst && free) begin
      for (int k = 0; k < N; k++) begin
        r = (m_ptr + k) % N;
        if (g < 0 && valid[r]) g = r;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 64'(bus.req_ready_o), 64'(er));
    check("out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() != 0));
    check("dbg_state", 64'(dbg), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("out_word", 64'({bus.out_filtered_o, bus.out_id_o, bus.out_data_o}), 64'(exp_q[0]));
    check("filt_cnt", 64'(cnt), 64'(m_cnt));
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;
      m_lfsr = SEED;
      m_cnt = 0;
    end else begin
      if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (g >= 0) begin
        md = int'(mode[2*g +: 2]);
        scrub(word[g], md, fx, fz, m_lfsr, sw, pop);
        exp_q.push_back({pop != 0, 2'(g), sw});
        m_ptr = (g + 1) % N;
        if (md == 2) m_lfsr = lfsr_next(m_lfsr);
      end
      if (clr) m_cnt = 0;
      else if (g >= 0) m_cnt = (m_cnt + pop > CNT_MAX) ? CNT_MAX : m_cnt + pop;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    tick(g);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    bit ordy;
    logic [N-1:0] exp_rdy;
    bit exp_ov;
    int exp_id;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int g;
    logic [W-1:0] w;
    total = 0; bad = 0;
    rst = 1'b1; valid = '0; ordy = 1'b0; mode = '0; fx = 1'b0; fz = 1'b0; clr = 1'b0;
    for (int r = 0; r < N; r++) word[r] = '0;
    m_ptr = 0; m_lfsr = SEED; m_cnt = 0;
    @(posedge clk);
    #1;
    tick(g);
    rst = 1'b0;

    // Reset then idle.
    repeat (3) begin
      tick(g);
      check("idle_data", 64'(bus.out_data_o), 64'(0));
      check("idle_id", 64'(bus.out_id_o), 64'(0));
      check("idle_filt", 64'(bus.out_filtered_o), 64'(0));
    end

    // Requester 1, zero fill, bit 0 unknown.
    fx = 1'b1; ordy = 1'b1;
    w = 32'h0000_00F0; w[0] = 1'bx;
    word[1] = w; valid[1] = 1'b1;
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    check("single_id", 64'(bus.out_id_o), 64'(1));
    tick(g);

    // Arbitration vector table from a fresh reset, all requesters in bypass.
    do_reset();
    mode = 8'hFF;
    for (int r = 0; r < N; r++) word[r] = 32'hA000_0000 | 32'(r);
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
    tbl[7]  = '{4'b1101, 1'b1, 4'b0100, 1'b1, 1};
    tbl[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 3};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 3};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
    for (int i = 0; i < 13; i++) begin
      valid = tbl[i].valid;
      ordy = tbl[i].ordy;
      #1;
      check("tbl_ready", 64'(bus.req_ready_o), 64'(tbl[i].exp_rdy));
      check("tbl_out_valid", 64'(bus.out_valid_o), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) check("tbl_id", 64'(bus.out_id_o), 64'(tbl[i].exp_id));
      tick(g);
    end

    // Output stalled for 5 cycles while requester 2 waits.
    ordy = 1'b0;
    word[0] = 32'h1234_5678; valid[0] = 1'b1;
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    word[2] = 32'hCAFE_0002; valid[2] = 1'b1;
    repeat (5) begin
      #1;
      check("stall_ready", 64'(bus.req_ready_o), 64'(0));
      check("stall_id", 64'(bus.out_id_o), 64'(0));
      check("stall_data", 64'(bus.out_data_o), 64'(32'h1234_5678));
      tick(g);
    end
    ordy = 1'b1;
    #1;
    check("release_ready", 64'(bus.req_ready_o), 64'(4'b0100));
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    tick(g);

    // Random fill of an all-unknown word straight after reset, then bypass of the same word.
    do_reset();
    mode = 8'b10_00_00_00; fx = 1'b1; fz = 1'b1; ordy = 1'b1;
    word[3] = 'x; valid[3] = 1'b1;
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    tick(g);
    mode = 8'b11_00_00_00;
    valid[3] = 1'b1;
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    tick(g);

    // Counter runs up to 16'hFFF0, saturates, then a clear beats a concurrent accept.
    do_reset();
    mode = '0; fx = 1'b1; fz = 1'b0; ordy = 1'b1;
    word[0] = 'x; valid[0] = 1'b1;
    repeat (2047) tick(g);
    w = '0; w[15:0] = 'x;
    word[0] = w;
    tick(g);
    word[0] = 'x;
    repeat (2) tick(g);
    clr = 1'b1;
    tick(g);
    clr = 1'b0;
    valid[0] = 1'b0;
    repeat (2) tick(g);

    // Reset while a word is held and another requester is waiting.
    ordy = 1'b0;
    word[1] = 32'h0BAD_F00D; valid[1] = 1'b1;
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    word[2] = 32'h0000_2222; valid[2] = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(bus.req_ready_o), 64'(0));
    tick(g);
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'(0));
    tick(g);
    if (g >= 0) valid[g] = 1'b0;
    ordy = 1'b1;
    tick(g);

    // Randomized traffic, config and clears.
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!valid[r] && $urandom_range(0, 2) == 0) begin
          valid[r] = 1'b1;
          word[r] = rand_word();
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        mode = 8'($urandom);
        fx = 1'($urandom_range(0, 1));
        fz = 1'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 39) == 0);
      tick(g);
      if (g >= 0) valid[g] = 1'b0;
    end
    clr = 1'b0; valid = '0; ordy = 1'b1;
    repeat (2) tick(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
